// File: rtl/uart_lowpower_rx.sv
// uart_lowpower_rx: low-power 8N1 UART receiver with idle-time SLEEP state.
// A falling edge on the synchronized line wakes the receiver from SLEEP or
// IDLE. Every sample is taken in the middle of its bit.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frame, live parity_err).
module uart_lowpower_rx #(
  parameter int CLKS_PER_BIT      = 16,
  parameter int IDLE_SLEEP_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [2:0] S_SLEEP  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDLE_W = $clog2(IDLE_SLEEP_CYCLES + 1);

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] IDLE_TRIP = IDLE_W'(IDLE_SLEEP_CYCLES - 1);

  logic              rx_meta;
  logic              rx_s;
  logic              rx_d;
  logic              fall;
  logic [BAUD_W-1:0] baud_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [2:0]        next_state;
  logic              tick_half;
  logic              tick_full;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall      = rx_d & ~rx_s;
  assign tick_half = (baud_cnt == HALF_LAST);
  assign tick_full = (baud_cnt == FULL_LAST);

  // Next-state decode of the receive FSM.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_SLEEP: if (fall) next_state = S_START;
      S_IDLE: begin
        if (fall)                             next_state = S_START;
        else if (rx_s && idle_cnt == IDLE_TRIP) next_state = S_SLEEP;
      end
      S_START: if (tick_half) next_state = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick_full && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
      end
      S_PARITY: if (tick_full) next_state = S_STOP;
      S_STOP:   if (tick_full) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // State register with a registered busy flag derived from the same decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == S_START) || (next_state == S_DATA) ||
               (next_state == S_PARITY) || (next_state == S_STOP);
    end
  end

  // Counters, shift register and one-cycle result pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt   <= '0;
      idle_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        S_SLEEP, S_IDLE: begin
          // SLEEP leaves every counter frozen until the wake-up edge.
          if (fall) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end else if (state == S_IDLE) begin
            if (!rx_s)                         idle_cnt <= '0;
            else if (idle_cnt != IDLE_TRIP + 1'b1) idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_START: baud_cnt <= tick_half ? '0 : baud_cnt + 1'b1;
        S_DATA: begin
          if (tick_full) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_full) begin
            baud_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            // Even parity: the parity bit must equal the XOR of the data.
            par_bad  <= rx_s ^ (^shift);
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_full) begin
            baud_cnt <= '0;
            idle_cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
`endif
            end else begin
              data_out   <= shift;
              data_valid <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: baud_cnt <= '0;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_lowpower_rx.sv
// tb_uart_lowpower_rx: directed plus randomized frames for uart_lowpower_rx.
// Expected results come from a frame-level model: a frame with a low stop bit
// gives frame_err, else a wrong parity bit gives parity_err, else the byte.
module tb_uart_lowpower_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;
  logic [2:0] state;

  uart_lowpower_rx #(.CLKS_PER_BIT(CPB), .IDLE_SLEEP_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy),
    .state      (state)
  );

  always #10 clk = ~clk;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         n_valid, n_ferr, n_perr, busy_cycles;
  bit         saw_start;
  logic [7:0] got[$];
  int         valid_cyc[$];
  logic [7:0] exp_data;

  always @(posedge clk) cyc++;

  // Pulse and state monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      got.push_back(data_out);
      valid_cyc.push_back(cyc);
    end
    if (frame_err)    n_ferr++;
    if (parity_err)   n_perr++;
    if (busy)         busy_cycles++;
    if (state == 3'd2) saw_start = 1'b1;
  end

  task automatic clear_mon();
    n_valid = 0; n_ferr = 0; n_perr = 0; busy_cycles = 0; saw_start = 1'b0;
    got.delete(); valid_cyc.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ flip);
`else
    if (flip) rx = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  {24'd0, data_out}, 32'h00);
    check({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_perr"},  {31'd0, parity_err}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_state"}, {29'd0, state}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    logic       stop_bad, flip;
    int         gap, delta;

    // Reset state.
    clear_mon();
    repeat (3) @(negedge clk);
    #1 check_reset_values("rst");
    @(negedge clk);
    rst = 1'b1;
    exp_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("post_rst");

    // Basic 8N1 frame 0xA5.
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_valid_cnt", n_valid, 1);
    check("a5_data", {24'd0, data_out}, 32'hA5);
    check("a5_ferr_cnt", n_ferr, 0);
    check("a5_busy_cycles", busy_cycles, CPB / 2 + (FRAME_BITS - 1) * CPB);
    check("a5_busy_end", {31'd0, busy}, 0);
    exp_data = 8'hA5;

    // Idle into SLEEP from a fresh reset, then wake on 0x3C.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_data = 8'h00;
    repeat (60) @(negedge clk);
    check("sleep_early_idle", {29'd0, state}, 32'd1);
    repeat (10) @(negedge clk);
    check("sleep_entered", {29'd0, state}, 32'd0);
    repeat (130) @(negedge clk);
    check("sleep_held", {29'd0, state}, 32'd0);
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0);
    check("wake_saw_start", {31'd0, saw_start}, 1);
    check("wake_valid_cnt", n_valid, 1);
    check("wake_data", {24'd0, data_out}, 32'h3C);
    check("wake_state_idle", {29'd0, state}, 32'd1);
    exp_data = 8'h3C;

    // Short low glitch: false start, no pulses, then a good 0x5A.
    clear_mon();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_saw_start", {31'd0, saw_start}, 1);
    check("glitch_pulses", n_valid + n_ferr + n_perr, 0);
    check("glitch_state", {29'd0, state}, 32'd1);
    check("glitch_data_kept", {24'd0, data_out}, {24'd0, exp_data});
    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b0);
    check("after_glitch_valid", n_valid, 1);
    check("after_glitch_data", {24'd0, data_out}, 32'h5A);
    exp_data = 8'h5A;

    // Framing error with a held break.
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("break_ferr_cnt", n_ferr, 1);
    check("break_valid_cnt", n_valid, 0);
    check("break_perr_cnt", n_perr, 0);
    check("break_data_kept", {24'd0, data_out}, {24'd0, exp_data});
    check("break_state", {29'd0, state}, 32'd1);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("break_no_new_frame", n_valid + n_ferr, 1);
    clear_mon();
    send_frame(8'hC3, 1'b1, 1'b0);
    check("after_break_data", {24'd0, data_out}, 32'hC3);
    exp_data = 8'hC3;

    // Reset during data bit 4 of 0xFF.
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b1;
    exp_data = 8'h00;
    repeat (40) @(negedge clk);
    check("midrst_no_pulse", n_valid + n_ferr + n_perr, 0);
    clear_mon();
    send_frame(8'h81, 1'b1, 1'b0);
    check("after_rst_valid", n_valid, 1);
    check("after_rst_data", {24'd0, data_out}, 32'h81);
    exp_data = 8'h81;

    // Back-to-back 0x12, 0x34.
    clear_mon();
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    check("b2b_valid_cnt", n_valid, 2);
    check("b2b_first", {24'd0, (got.size() > 0) ? got[0] : 8'hxx}, 32'h12);
    check("b2b_second", {24'd0, (got.size() > 1) ? got[1] : 8'hxx}, 32'h34);
    delta = (valid_cyc.size() == 2) ? valid_cyc[1] - valid_cyc[0] : -1;
    check("b2b_spacing", delta, FRAME_BITS * CPB);
    exp_data = 8'h34;

`ifdef UART_RX_PARITY_EN
    // Back-to-back with a bad parity bit on the second frame.
    clear_mon();
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1);
    check("par_valid_cnt", n_valid, 1);
    check("par_perr_cnt", n_perr, 1);
    check("par_ferr_cnt", n_ferr, 0);
    check("par_data_kept", {24'd0, data_out}, 32'h12);
    exp_data = 8'h12;
`endif

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 10; n++) begin
      b        = 8'($urandom);
      stop_bad = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
      flip     = ($urandom_range(0, 3) == 0);
`else
      flip     = 1'b0;
`endif
      gap      = $urandom_range(4, 40);
      clear_mon();
      send_frame(b, ~stop_bad, flip);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
      if (!stop_bad && !flip) exp_data = b;
      check($sformatf("rand%0d_valid", n), n_valid, (!stop_bad && !flip) ? 1 : 0);
      check($sformatf("rand%0d_ferr", n), n_ferr, stop_bad ? 1 : 0);
      check($sformatf("rand%0d_perr", n), n_perr, (!stop_bad && flip) ? 1 : 0);
      check($sformatf("rand%0d_data", n), {24'd0, data_out}, {24'd0, exp_data});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_lowpower_rx.md
# uart_lowpower_rx

Low-power UART receiver; the receive-side counterpart of the low-power UART transmitter top. It deserialises 8N1 frames (optionally 8E1) from the serial line, presents each byte with a one-cycle valid strobe, and flags framing errors. After a programmable idle time it drops into a SLEEP state in which the bit-timing counter is frozen, and it wakes on the falling edge of a start bit.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be even and ≥ 4.
- `IDLE_SLEEP_CYCLES`, default 64: consecutive line-high cycles in IDLE before entering SLEEP; must be ≥ 1.
- `clk` input, 1: system clock, single clock domain.
- `rst` input, 1: asynchronous, active-low reset.
- `rx` input, 1: serial line, asynchronous to `clk`, idle high.
- `data_out` output, 8: last correctly received byte, LSB first on the line.
- `data_valid` output, 1: one-cycle pulse; `data_out` is updated in the same cycle.
- `frame_err` output, 1: one-cycle pulse; the stop bit was sampled low.
- `parity_err` output, 1: one-cycle pulse; parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.
- `busy` output, 1: high in the START, DATA, PARITY and STOP states.
- `state` output, 3: current FSM state, encoded SLEEP=0, IDLE=1, START=2, DATA=3, STOP=4, PARITY=5.

## Operation
- `rx` passes through a 2-FF synchronizer; both flops reset to 1. The FSM uses only the synchronized value `rx_s` and its registered copy, which gives falling-edge detection.
- IDLE: the idle counter increments each cycle while `rx_s`=1 and clears when `rx_s`=0.
  - The counter reaching `IDLE_SLEEP_CYCLES` moves the FSM to SLEEP.
  - A falling edge moves the FSM to START and clears the bit counter.
- SLEEP: the baud counter, bit counter and idle counter are held (no toggling). A falling edge on `rx_s` moves the FSM to START, the same as from IDLE.
- START: count `CLKS_PER_BIT/2` cycles to the middle of the start bit.
  - If `rx_s`=1 there, the start is false: go to IDLE, no pulse.
  - Otherwise go to DATA.
- DATA: sample `rx_s` every `CLKS_PER_BIT` cycles and shift it into a shift register, LSB first. After the 8th sample, go to PARITY if enabled, otherwise STOP.
- PARITY: sample one bit; the mismatch result is held until the end of STOP.
- STOP: sample once at the middle of the stop bit, then return to IDLE.
  - `rx_s`=1 and no parity error: load `data_out` and pulse `data_valid`.
  - `rx_s`=0: pulse `frame_err`; `data_out` is unchanged.
  - Parity error with a good stop bit: pulse `parity_err`; `data_out` is unchanged.
  - A framing error takes precedence; only `frame_err` pulses.
- Break handling: after a framing error, a line held low produces no new frame until `rx_s` returns high and falls again.

## Timing
- Reset values: `data_out`=0x00, `data_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, `state`=IDLE (1). All counters are 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately with no pulse.
- From an `rx` edge to the `rx_s` edge: 2 cycles.
- The FSM enters START in the cycle after the `rx_s` falling edge is registered.
- Data bit k (0..7) is sampled `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT` cycles after START entry. Parity, when enabled, is sampled one bit period after bit 7. Stop is sampled one bit period after the last data or parity bit.
- Output pulses are registered and assert in the cycle after the stop sample. `state` is IDLE in that same cycle.
- Back-to-back frames: a new start bit that immediately follows the stop bit is accepted, because detection resumes in IDLE about half a bit before the stop bit ends.
- `busy` and `state` are registered and track the FSM with zero added latency.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is start, 8 data bits, even parity, stop. The PARITY state is reachable and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1. The PARITY state is never entered and `parity_err` is constant 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and a 50 MHz clock.
- Send 0xA5 as 8N1 after reset: one `data_valid` pulse, `data_out`=0xA5, `frame_err`=0, and `busy` high for about 9.5 bit periods.
- Hold the line idle for 200 cycles: `state` reaches SLEEP (0) after 64 cycles. Then send 0x3C: the block wakes to START, `data_out`=0x3C, and `state` ends in IDLE.
- Drive a 4-cycle low glitch on `rx`: the FSM enters START and returns to IDLE with no `data_valid`, `frame_err` or `parity_err`. Then send a valid 0x5A: it is received correctly.
- Send 0x55 with the stop bit driven low, and keep the line low for 3 bit periods: a single `frame_err` pulse, `data_out` keeps its previous value, and no second frame is seen until the line goes high and then low.
- Assert reset during data bit 4 of 0xFF: the outputs take their reset values immediately. After release, send 0x81: it is received correctly.
- Send 0x12 and 0x34 back-to-back with no idle gap: two `data_valid` pulses, 10 bit periods apart, in that order. With `UART_RX_PARITY_EN`, repeat with the parity bit inverted on the second frame: `parity_err` pulses and `data_out` stays 0x12.
